// File: rtl/seg7_capture.sv
// Receiving end of a multiplexed active-low 7-segment bus: recovers the four
// displayed digits, decodes them into a number or the "Err" pattern, and flags a stalled driver.
module seg7_capture #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 262144
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [13:0] value,
  output logic        show_error,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic        decode_err,
  output logic        stalled
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  logic [6:0]    s_seg, p_seg;
  logic [3:0]    s_an, p_an;
  logic [SW-1:0] stab_cnt, stab_next;
  logic [IW-1:0] idle_cnt, idle_next;
  logic [15:0]   slots;
  logic [3:0]    mask, mask_next;

  logic          legal, same, capture, complete, timeout_hit;
  logic [1:0]    sel_idx;
  logic [3:0]    sel_bit;
  logic [3:0]    glyph_code;
  logic          is_err_frame, all_decimal;
  logic [13:0]   dec_value;

  // Select decode: exactly one active-low enable identifies the digit slot.
  always_comb begin
    legal   = 1'b1;
    sel_idx = 2'd0;
    case (s_an)
      4'b1110: sel_idx = 2'd0;
      4'b1101: sel_idx = 2'd1;
      4'b1011: sel_idx = 2'd2;
      4'b0111: sel_idx = 2'd3;
      default: legal = 1'b0;
    endcase
    sel_bit = 4'b0001 << sel_idx;
  end

  always_comb begin
    case (s_seg)
      7'b1000000: glyph_code = 4'd0;
      7'b1111001: glyph_code = 4'd1;
      7'b0100100: glyph_code = 4'd2;
      7'b0110000: glyph_code = 4'd3;
      7'b0011001: glyph_code = 4'd4;
      7'b0010010: glyph_code = 4'd5;
      7'b0000010: glyph_code = 4'd6;
      7'b1111000: glyph_code = 4'd7;
      7'b0000000: glyph_code = 4'd8;
      7'b0010000: glyph_code = 4'd9;
      7'b0000110: glyph_code = 4'd10;
      7'b0101111: glyph_code = 4'd11;
      7'b1111111: glyph_code = 4'd12;
      default:    glyph_code = 4'd15;
    endcase
  end

  // Capture fires only on the step where the counter first reaches STABLE_CYCLES.
  always_comb begin
    same    = (s_seg == p_seg) && (s_an == p_an);
    capture = legal && same && (stab_cnt == SW'(STABLE_CYCLES - 1));
    if (!same || !legal)
      stab_next = SW'(1);
    else if (stab_cnt != SW'(STABLE_CYCLES))
      stab_next = stab_cnt + SW'(1);
    else
      stab_next = stab_cnt;
  end

  always_comb begin
    timeout_hit = !capture && (idle_cnt == IW'(TIMEOUT_CYCLES - 1));
    if (capture)
      idle_next = '0;
    else if (idle_cnt != IW'(TIMEOUT_CYCLES))
      idle_next = idle_cnt + IW'(1);
    else
      idle_next = idle_cnt;
    complete  = (mask == 4'hF);
    mask_next = ((complete || timeout_hit) ? 4'h0 : mask) | (capture ? sel_bit : 4'h0);
  end

  always_comb begin
    is_err_frame = (slots == 16'hABBC);
    all_decimal  = (slots[3:0] <= 4'd9) && (slots[7:4] <= 4'd9) &&
                   (slots[11:8] <= 4'd9) && (slots[15:12] <= 4'd9);
    dec_value    = 14'(slots[15:12]) * 14'd1000 + 14'(slots[11:8]) * 14'd100 +
                   14'(slots[7:4]) * 14'd10 + 14'(slots[3:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_seg       <= '1;
      s_an        <= '1;
      p_seg       <= '1;
      p_an        <= '1;
      stab_cnt    <= '0;
      idle_cnt    <= '0;
      slots       <= '0;
      mask        <= '0;
      value       <= '0;
      show_error  <= 1'b0;
      digits      <= '0;
      frame_valid <= 1'b0;
      decode_err  <= 1'b0;
      stalled     <= 1'b0;
    end else begin
      s_seg       <= seg;
      s_an        <= an;
      p_seg       <= s_seg;
      p_an        <= s_an;
      stab_cnt    <= stab_next;
      idle_cnt    <= idle_next;
      mask        <= mask_next;
      frame_valid <= complete;
      if (capture)
        slots[4*sel_idx +: 4] <= glyph_code;
      if (capture)
        stalled <= 1'b0;
      else if (timeout_hit)
        stalled <= 1'b1;
      // A completed frame uses the slot contents as they stood before any same-cycle capture.
      if (complete) begin
        digits <= slots;
        if (is_err_frame) begin
          show_error <= 1'b1;
          decode_err <= 1'b0;
          value      <= '0;
        end else if (all_decimal) begin
          show_error <= 1'b0;
          decode_err <= 1'b0;
          value      <= dec_value;
        end else begin
          show_error <= 1'b0;
          decode_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture: expected frames are queued as the digits
// are driven and compared whenever the DUT pulses frame_valid.
module tb_seg7_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [13:0] value;
  logic        show_error;
  logic [15:0] digits;
  logic        frame_valid;
  logic        decode_err;
  logic        stalled;

  typedef struct packed {
    logic [13:0] value;
    logic        show_error;
    logic        decode_err;
    logic [15:0] digits;
  } frame_t;

  frame_t      exp_q[$];
  logic [13:0] model_value = '0;
  int          compared    = 0;
  int          mismatched  = 0;

  seg7_capture #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .seg(seg), .an(an), .value(value),
    .show_error(show_error), .digits(digits), .frame_valid(frame_valid),
    .decode_err(decode_err), .stalled(stalled)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input int code);
    case (code)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      10: return 7'b0000110;
      11: return 7'b0101111;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference model of frame interpretation, tracking the held value.
  task automatic expectFrame(input logic [15:0] codes);
    frame_t e;
    logic   dec_ok;
    e.digits = codes;
    dec_ok = 1'b1;
    for (int i = 0; i < 4; i++)
      if (codes[4*i +: 4] > 4'd9) dec_ok = 1'b0;
    if (codes == 16'hABBC) begin
      e.value = '0; e.show_error = 1'b1; e.decode_err = 1'b0;
    end else if (dec_ok) begin
      e.value = 14'(int'(codes[15:12]) * 1000 + int'(codes[11:8]) * 100 +
                    int'(codes[7:4]) * 10 + int'(codes[3:0]));
      e.show_error = 1'b0; e.decode_err = 1'b0;
    end else begin
      e.value = model_value; e.show_error = 1'b0; e.decode_err = 1'b1;
    end
    model_value = e.value;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input int idx, input logic [6:0] g, input int cyc);
    seg = g;
    an  = ~(4'b0001 << idx);
    repeat (cyc) @(negedge clk);
  endtask

  task automatic driveFrame(input logic [15:0] codes);
    expectFrame(codes);
    for (int i = 0; i < 4; i++)
      applyStimulus(i, glyph(int'(codes[4*i +: 4])), 16);
  endtask

  always @(negedge clk) begin
    if (frame_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_frame", 32'd1, 32'd0);
      end else begin
        frame_t e;
        e = exp_q.pop_front();
        checkOutput("value", 32'(value), 32'(e.value));
        checkOutput("show_error", 32'(show_error), 32'(e.show_error));
        checkOutput("decode_err", 32'(decode_err), 32'(e.decode_err));
        checkOutput("digits", 32'(digits), 32'(e.digits));
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_value"}, 32'(value), 32'd0);
    checkOutput({tag, "_digits"}, 32'(digits), 32'd0);
    checkOutput({tag, "_show_error"}, 32'(show_error), 32'd0);
    checkOutput({tag, "_decode_err"}, 32'(decode_err), 32'd0);
    checkOutput({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
    checkOutput({tag, "_stalled"}, 32'(stalled), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    seg   = 7'h7F;
    an    = 4'hF;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;

    driveFrame(16'h1234);
    driveFrame(16'h1234);
    driveFrame(16'hABBC);

    // Digit 2 briefly shows an unstable "8" before settling on "0".
    expectFrame(16'h0002);
    applyStimulus(0, glyph(2), 16);
    applyStimulus(1, glyph(0), 16);
    applyStimulus(2, 7'b0000000, 3);
    applyStimulus(2, glyph(0), 16);
    applyStimulus(3, glyph(0), 16);

    // Two enables low at once for three cycles between digits.
    expectFrame(16'h5678);
    applyStimulus(0, glyph(8), 16);
    applyStimulus(1, glyph(7), 16);
    seg = glyph(6);
    an  = 4'b1100;
    repeat (3) @(negedge clk);
    applyStimulus(2, glyph(6), 16);
    applyStimulus(3, glyph(5), 16);

    driveFrame(16'h0042);
    expectFrame(16'h00F2);
    applyStimulus(0, glyph(2), 16);
    applyStimulus(1, 7'b1010101, 16);
    applyStimulus(2, glyph(0), 16);
    applyStimulus(3, glyph(0), 16);
    checkOutput("held_value", 32'(value), 32'd42);

    // Driver freezes after two digits; capture of digit 1 lands on the 5th edge.
    applyStimulus(0, glyph(3), 16);
    applyStimulus(1, glyph(1), 68);
    checkOutput("stalled_idle63", 32'(stalled), 32'd0);
    @(negedge clk);
    checkOutput("stalled_idle64", 32'(stalled), 32'd1);
    repeat (10) @(negedge clk);
    checkOutput("stalled_hold", 32'(stalled), 32'd1);
    expectFrame(16'h9876);
    applyStimulus(2, glyph(8), 5);
    checkOutput("stalled_cleared", 32'(stalled), 32'd0);
    repeat (11) @(negedge clk);
    applyStimulus(3, glyph(9), 16);
    applyStimulus(0, glyph(6), 16);
    applyStimulus(1, glyph(7), 16);

    // Reset arrives with three of four digits captured.
    applyStimulus(0, glyph(1), 16);
    applyStimulus(1, glyph(2), 16);
    applyStimulus(2, glyph(3), 16);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkAllZero("midframe_reset");
    driveFrame(16'h4321);

    repeat (20) @(negedge clk);
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
